layer_mixer: RTL and testbench
==============================

# layer_mixer

Parametrised, pipelined layer compositor for the gfx path. It takes per-pixel colour and hit flags from NUM_LAYERS sprite and overlay generators plus a background colour, and registers the winning colour using a per-layer priority and enable table. Table changes take effect only at frame boundaries. It also accumulates per-frame collisions between a watched layer (the player sprite) and every other layer, and reports them to the game FSM once per frame. It sits between the sprite/digit/barrier generators and the video output.

## Interface
- NUM_LAYERS, 16: number of foreground layers; index 0..NUM_LAYERS-1.
- COLOR_W, 8: bits per colour channel.
- COORD_W, 16: width of pixel coordinates.
- WATCH_LAYER, 0: layer whose overlaps are reported as collisions.
- PRIO_W, $clog2(NUM_LAYERS): width of a priority value (derived, not overridden).

Ports:
- i_clk  in  1  pixel clock; single clock domain.
- i_rst_n  in  1  asynchronous active-low reset.
- i_pix_valid  in  1  current pixel is in the active area.
- i_x, i_y  in  COORD_W each  current pixel coordinate.
- i_v_sync  in  1  vertical sync, synchronous to i_clk; its rising edge marks the frame boundary.
- i_layer_rgb  in  NUM_LAYERS*3*COLOR_W  packed {r,g,b} per layer, with layer 0 in the LSBs.
- i_layer_hit  in  NUM_LAYERS  layer has an opaque pixel here.
- i_bg_rgb  in  3*COLOR_W  background {r,g,b}.
- i_cfg_we  in  1  write the shadow configuration entry.
- i_cfg_layer  in  $clog2(NUM_LAYERS)  entry index.
- i_cfg_en  in  1  layer enable value.
- i_cfg_prio  in  PRIO_W  priority value; lower wins.
- o_red, o_green, o_blue  out  COLOR_W each  composited colour.
- o_valid  out  1  i_pix_valid delayed to align with the colour.
- o_x, o_y  out  COORD_W each  coordinates aligned with the colour.
- o_collide  out  NUM_LAYERS  collision mask for the last completed frame.
- o_collide_valid  out  1  one-cycle pulse when o_collide updates.

## Operation
- **Two configuration tables.** Both hold en[i] and prio[i].
  - The shadow table is written by i_cfg_we.
  - The active table is used for arbitration.
  - The active table is loaded from the shadow table on each frame-boundary cycle.
- **Frame boundary.** A cycle where i_v_sync is 1 and its registered previous value is 0.
- **Config write on a boundary cycle.** The copy takes the pre-write shadow value. The new write applies at the following boundary.
- **Arbitration.**
  - Candidates are the layers i with i_layer_hit[i] and active en[i].
  - The winner is the candidate with the smallest prio. Equal prio goes to the lower index.
  - With no candidate, the output is i_bg_rgb.
- **Collision.** On a cycle with i_pix_valid, hit[WATCH_LAYER] and en[WATCH_LAYER], each layer j ≠ WATCH_LAYER with hit[j] and en[j] sets accumulator bit j. Bit WATCH_LAYER is never set.
- **On a boundary cycle:**
  - o_collide loads the accumulator, ORed with any collision in that same cycle.
  - o_collide_valid pulses for that cycle.
  - The accumulator clears to 0.
- **Disabled layers.** A disabled layer never wins arbitration and never collides.
- **Reset values:**
  - shadow and active tables: en = all 1, prio[i] = i (low bits of i if i exceeds the PRIO_W range).
  - accumulator, o_collide: 0.
  - o_collide_valid, o_valid: 0.
  - o_red, o_green, o_blue, o_x, o_y: 0.
  - v_sync history register: 0, so an i_v_sync held high through reset release produces a boundary on the first clock.

## Timing
- **Colour path latency: 2 cycles.**
  - Stage 1 registers the inputs and the winner index (or background select).
  - Stage 2 registers the muxed colour, o_valid, o_x and o_y.
  - Throughput is one pixel per cycle with no stalls.
- **Colour with o_valid = 0.** Colour is still composited; downstream ignores it.
- **Collision path.** The accumulator updates in the same cycle as the inputs. o_collide is registered, so the pulse is 1 cycle after the boundary cycle's inputs.
- **Table switch.** The active table switches at the end of the boundary cycle. Pixels entering on the next cycle use the new table; pixels already in the pipeline keep their old winner.
- **Reset.** Asynchronous assert clears all state immediately, including mid-frame and mid-pipeline. Deassert is expected to be synchronised externally.

## Structure
- Shared package gfx_pkg holds:
  - the rgb_t packed struct {r,g,b} of COLOR_W, and its pack/unpack helpers;
  - the default priority function (prio = index).
- Sub-module layer_arbiter: a purely combinational min-priority tree over NUM_LAYERS with lower-index tie-break. It outputs the winner index and an any-hit flag, and is instantiated once in stage 1.
- All remaining logic lives in layer_mixer: config tables, edge detect, collision accumulator and pipeline registers.

## Test plan
- **Reset defaults.** Reset, then hits on layers 3 and 5 with no config writes → output is layer 3's colour 2 cycles later; o_valid and o_x/o_y aligned.
- **Reprogrammed priority.** Write prio[5] = 0 and prio[3] = 2 mid-frame → layer 3 still wins until the next i_v_sync rise. From the following cycle, layer 5 wins.
- **Tie, disable, background.** prio[2] = prio[7] = 4 with both hit → layer 2 wins. Disable layer 2 → layer 7 wins. Disable both → i_bg_rgb.
- **Collision reporting.** With WATCH_LAYER = 0, overlap 0 with 4 in frame N, and 0 with 9 only on cycles where i_pix_valid = 0 → at the boundary, o_collide = 16'h0010 and o_collide_valid is high for 1 cycle. The next frame with no overlap gives o_collide = 0.
- **Boundary-cycle collision.** A collision on the exact boundary cycle is included in the reported mask, and the accumulator is 0 afterward.
- **Reset mid-frame.** Assert i_rst_n low mid-frame with collisions pending and config written → all outputs and tables return to reset values immediately. No o_collide_valid pulse occurs until the next boundary.

Source files
------------

// File: rtl/gfx_pkg.sv
// gfx_pkg: shared colour type, pack/unpack helpers and reset priority for the gfx path.
package gfx_pkg;
    localparam int CH_W = 8;
    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_t;
    function automatic rgb_t rgb_unpack(input logic [3*CH_W-1:0] v);
        return rgb_t'(v);
    endfunction
    function automatic logic [3*CH_W-1:0] rgb_pack(input rgb_t c);
        return c;
    endfunction
    // Wraps to the low bits of the index when the layer count exceeds the priority range.
    function automatic int default_prio(input int idx, input int w);
        return idx % (1 << w);
    endfunction
endpackage

// File: rtl/layer_mixer_if.sv
// layer_mixer_if: pixel, configuration and composited-output signals of the layer mixer.
interface layer_mixer_if #(
    parameter int NUM_LAYERS = 16,
    parameter int COLOR_W    = 8,
    parameter int COORD_W    = 16
);
    localparam int PRIO_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    logic                            i_pix_valid;
    logic [COORD_W-1:0]              i_x;
    logic [COORD_W-1:0]              i_y;
    logic                            i_v_sync;
    logic [NUM_LAYERS*3*COLOR_W-1:0] i_layer_rgb;
    logic [NUM_LAYERS-1:0]           i_layer_hit;
    logic [3*COLOR_W-1:0]            i_bg_rgb;
    logic                            i_cfg_we;
    logic [PRIO_W-1:0]               i_cfg_layer;
    logic                            i_cfg_en;
    logic [PRIO_W-1:0]               i_cfg_prio;
    logic [COLOR_W-1:0]              o_red;
    logic [COLOR_W-1:0]              o_green;
    logic [COLOR_W-1:0]              o_blue;
    logic                            o_valid;
    logic [COORD_W-1:0]              o_x;
    logic [COORD_W-1:0]              o_y;
    logic [NUM_LAYERS-1:0]           o_collide;
    logic                            o_collide_valid;
    modport master (
        output i_pix_valid, i_x, i_y, i_v_sync, i_layer_rgb, i_layer_hit, i_bg_rgb,
               i_cfg_we, i_cfg_layer, i_cfg_en, i_cfg_prio,
        input  o_red, o_green, o_blue, o_valid, o_x, o_y, o_collide, o_collide_valid
    );
    modport slave (
        input  i_pix_valid, i_x, i_y, i_v_sync, i_layer_rgb, i_layer_hit, i_bg_rgb,
               i_cfg_we, i_cfg_layer, i_cfg_en, i_cfg_prio,
        output o_red, o_green, o_blue, o_valid, o_x, o_y, o_collide, o_collide_valid
    );
endinterface

// File: rtl/layer_arbiter.sv
// layer_arbiter: combinational min-priority select over all layers, lower index wins ties.
module layer_arbiter #(
    parameter int NUM_LAYERS = 16,
    parameter int PRIO_W     = 4
)(
    input  logic [NUM_LAYERS-1:0]        cand,
    input  logic [NUM_LAYERS*PRIO_W-1:0] prio,
    output logic [PRIO_W-1:0]            win,
    output logic                         any
);
    logic [PRIO_W-1:0] best;
    // Strict less-than keeps the earlier (lower-index) layer on equal priority.
    always_comb begin
        win  = '0;
        any  = 1'b0;
        best = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (cand[i] && (!any || prio[i*PRIO_W +: PRIO_W] < best)) begin
                win  = PRIO_W'(i);
                best = prio[i*PRIO_W +: PRIO_W];
                any  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/layer_mixer.sv
// layer_mixer: two-stage priority compositor with frame-latched config tables and per-frame collision report.
module layer_mixer
    import gfx_pkg::*;
#(
    parameter int NUM_LAYERS  = 16,
    parameter int COLOR_W     = 8,
    parameter int COORD_W     = 16,
    parameter int WATCH_LAYER = 0
)(
    input logic        i_clk,
    input logic        i_rst_n,
    layer_mixer_if.slave bus
);
    localparam int PRIO_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int PIX_W  = 3 * COLOR_W;
    logic                            v_sync_q;
    logic                            boundary;
    logic [NUM_LAYERS-1:0]           sh_en;
    logic [NUM_LAYERS-1:0]           act_en;
    logic [PRIO_W-1:0]               sh_prio  [NUM_LAYERS];
    logic [PRIO_W-1:0]               act_prio [NUM_LAYERS];
    logic [NUM_LAYERS*PRIO_W-1:0]    act_prio_flat;
    logic [NUM_LAYERS-1:0]           cand;
    logic [PRIO_W-1:0]               win;
    logic                            any;
    logic [NUM_LAYERS-1:0]           coll_now;
    logic [NUM_LAYERS-1:0]           acc;
    logic [NUM_LAYERS*PIX_W-1:0]     s1_rgb;
    logic [PIX_W-1:0]                s1_bg;
    logic [PRIO_W-1:0]               s1_win;
    logic                            s1_any;
    logic                            s1_valid;
    logic [COORD_W-1:0]              s1_x;
    logic [COORD_W-1:0]              s1_y;
    logic [PIX_W-1:0]                pix_q;

    assign boundary = bus.i_v_sync && !v_sync_q;
    assign cand     = bus.i_layer_hit & act_en;
    assign coll_now = (bus.i_pix_valid && bus.i_layer_hit[WATCH_LAYER] && act_en[WATCH_LAYER])
                    ? (cand & ~(NUM_LAYERS'(1) << WATCH_LAYER)) : '0;

    always_comb begin
        act_prio_flat = '0;
        for (int i = 0; i < NUM_LAYERS; i++) act_prio_flat[i*PRIO_W +: PRIO_W] = act_prio[i];
    end

    layer_arbiter #(.NUM_LAYERS(NUM_LAYERS), .PRIO_W(PRIO_W)) u_arb (
        .cand (cand),
        .prio (act_prio_flat),
        .win  (win),
        .any  (any)
    );

    // The copy reads the shadow before this cycle's write lands, so a boundary-cycle write waits a frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v_sync_q <= 1'b0;
            sh_en    <= '1;
            act_en   <= '1;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                sh_prio[i]  <= PRIO_W'(default_prio(i, PRIO_W));
                act_prio[i] <= PRIO_W'(default_prio(i, PRIO_W));
            end
        end else begin
            v_sync_q <= bus.i_v_sync;
            if (boundary) begin
                act_en   <= sh_en;
                act_prio <= sh_prio;
            end
            if (bus.i_cfg_we) begin
                sh_en[bus.i_cfg_layer]   <= bus.i_cfg_en;
                sh_prio[bus.i_cfg_layer] <= bus.i_cfg_prio;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc                 <= '0;
            bus.o_collide       <= '0;
            bus.o_collide_valid <= 1'b0;
        end else begin
            acc                 <= boundary ? '0 : (acc | coll_now);
            bus.o_collide       <= boundary ? (acc | coll_now) : bus.o_collide;
            bus.o_collide_valid <= boundary;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_rgb      <= '0;
            s1_bg       <= '0;
            s1_win      <= '0;
            s1_any      <= 1'b0;
            s1_valid    <= 1'b0;
            s1_x        <= '0;
            s1_y        <= '0;
            pix_q       <= '0;
            bus.o_valid <= 1'b0;
            bus.o_x     <= '0;
            bus.o_y     <= '0;
        end else begin
            s1_rgb      <= bus.i_layer_rgb;
            s1_bg       <= bus.i_bg_rgb;
            s1_win      <= win;
            s1_any      <= any;
            s1_valid    <= bus.i_pix_valid;
            s1_x        <= bus.i_x;
            s1_y        <= bus.i_y;
            pix_q       <= s1_any ? s1_rgb[int'(s1_win)*PIX_W +: PIX_W] : s1_bg;
            bus.o_valid <= s1_valid;
            bus.o_x     <= s1_x;
            bus.o_y     <= s1_y;
        end
    end

    assign bus.o_red   = pix_q[2*COLOR_W +: COLOR_W];
    assign bus.o_green = pix_q[COLOR_W +: COLOR_W];
    assign bus.o_blue  = pix_q[0 +: COLOR_W];
endmodule

// File: tb/tb_layer_mixer.sv
// tb_layer_mixer: directed and random stimulus against a frame-level reference model of the mixer.
module tb_layer_mixer;
    import gfx_pkg::*;
    localparam int N = 16, CW = 8, XW = 16, WL = 0;
    typedef struct {logic [23:0] rgb; logic v; logic [15:0] x; logic [15:0] y;} pix_t;
    typedef struct {logic [15:0] c; logic cv;} col_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    layer_mixer_if #(.NUM_LAYERS(N), .COLOR_W(CW), .COORD_W(XW)) bus ();
    layer_mixer #(.NUM_LAYERS(N), .COLOR_W(CW), .COORD_W(XW), .WATCH_LAYER(WL)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    bit          m_sh_en [N];
    bit          m_act_en [N];
    int          m_sh_prio [N];
    int          m_act_prio [N];
    bit          m_vs_prev;
    logic [15:0] m_acc, m_col, xc;
    pix_t        pq[$];
    col_t        cq[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sh_en[i] = 1; m_act_en[i] = 1; m_sh_prio[i] = i; m_act_prio[i] = i;
        end
        m_vs_prev = 0; m_acc = '0; m_col = '0;
        pq.delete(); cq.delete();
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_red"}, bus.o_red, 0);
        check({tag, "_green"}, bus.o_green, 0);
        check({tag, "_blue"}, bus.o_blue, 0);
        check({tag, "_valid"}, bus.o_valid, 0);
        check({tag, "_xy"}, {bus.o_x, bus.o_y}, 0);
        check({tag, "_collide"}, bus.o_collide, 0);
        check({tag, "_cvalid"}, bus.o_collide_valid, 0);
    endtask

    task automatic step(input logic vs, input logic pv, input logic [N-1:0] hit,
                        input logic we = 0, input int cl = 0, input logic ce = 1, input int cp = 0);
        pix_t        e;
        col_t        c;
        rgb_t        er;
        int          win;
        bit          bnd;
        logic [15:0] now_c;
        @(negedge clk);
        if (pq.size() >= 2) begin
            e  = pq.pop_front();
            er = rgb_unpack(e.rgb);
            check("red", bus.o_red, er.r);
            check("green", bus.o_green, er.g);
            check("blue", bus.o_blue, er.b);
            check("o_valid", bus.o_valid, e.v);
            check("o_x", bus.o_x, e.x);
            check("o_y", bus.o_y, e.y);
        end
        if (cq.size() >= 1) begin
            c = cq.pop_front();
            check("collide", bus.o_collide, c.c);
            check("collide_valid", bus.o_collide_valid, c.cv);
        end
        bus.i_v_sync = vs; bus.i_pix_valid = pv; bus.i_layer_hit = hit;
        for (int i = 0; i < N; i++) bus.i_layer_rgb[i*24 +: 24] = 24'($urandom);
        bus.i_bg_rgb = 24'($urandom);
        bus.i_x = xc; bus.i_y = xc ^ 16'h5a5a; xc++;
        bus.i_cfg_we = we; bus.i_cfg_layer = 4'(cl); bus.i_cfg_en = ce; bus.i_cfg_prio = 4'(cp);
        // Reference: scan priority levels from best to worst, lowest index first within a level.
        win = -1;
        for (int p = 0; p < N; p++)
            for (int i = 0; i < N; i++)
                if (win < 0 && hit[i] && m_act_en[i] && m_act_prio[i] == p) win = i;
        e.rgb = (win >= 0) ? bus.i_layer_rgb[win*24 +: 24] : bus.i_bg_rgb;
        e.v = pv; e.x = bus.i_x; e.y = bus.i_y;
        pq.push_back(e);
        now_c = '0;
        if (pv && hit[WL] && m_act_en[WL])
            for (int j = 0; j < N; j++) if (j != WL && hit[j] && m_act_en[j]) now_c[j] = 1'b1;
        bnd = vs && !m_vs_prev;
        if (bnd) begin m_col = m_acc | now_c; m_acc = '0; end
        else m_acc = m_acc | now_c;
        c.c = m_col; c.cv = bnd;
        cq.push_back(c);
        if (bnd) begin m_act_en = m_sh_en; m_act_prio = m_sh_prio; end
        if (we) begin m_sh_en[cl] = ce; m_sh_prio[cl] = cp; end
        m_vs_prev = vs;
    endtask

    task automatic after_edge_collide(input string tag, input logic [15:0] exp);
        @(posedge clk);
        #1;
        check({tag, "_mask"}, bus.o_collide, exp);
        check({tag, "_pulse"}, bus.o_collide_valid, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_pix_valid = 0; bus.i_x = 0; bus.i_y = 0; bus.i_v_sync = 0;
        bus.i_layer_rgb = '0; bus.i_layer_hit = '0; bus.i_bg_rgb = '0;
        bus.i_cfg_we = 0; bus.i_cfg_layer = 0; bus.i_cfg_en = 0; bus.i_cfg_prio = 0;
        xc = 16'h0100;
        #1 rst_n = 1'b0;
        #1 check_reset_outs("reset");
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) step(0, 1, 16'h0028);
        step(0, 1, 16'h0028, 1, 5, 1, 0);
        step(0, 1, 16'h0028, 1, 3, 1, 2);
        repeat (3) step(0, 1, 16'h0028);
        repeat (3) step(1, 1, 16'h0028);
        repeat (3) step(0, 1, 16'h0028);
        step(0, 1, 16'h0084, 1, 2, 1, 4);
        step(0, 1, 16'h0084, 1, 7, 1, 4);
        step(1, 1, 16'h0084);
        repeat (3) step(0, 1, 16'h0084);
        step(0, 1, 16'h0084, 1, 2, 0, 4);
        step(1, 1, 16'h0084);
        repeat (3) step(0, 1, 16'h0084);
        step(0, 1, 16'h0084, 1, 7, 0, 4);
        step(1, 1, 16'h0084);
        repeat (3) step(0, 1, 16'h0084);
        repeat (2) step(0, 1, 16'h0011);
        repeat (2) step(0, 0, 16'h0201);
        step(0, 1, 16'h0000);
        step(1, 1, 16'h0000);
        after_edge_collide("frame_n", 16'h0010);
        repeat (4) step(0, 1, 16'h0030);
        step(1, 1, 16'h0000);
        after_edge_collide("frame_quiet", 16'h0000);
        step(0, 1, 16'h0000);
        step(1, 1, 16'h0041);
        after_edge_collide("bnd_cycle", 16'h0040);
        repeat (3) step(0, 1, 16'h0000);
        step(1, 1, 16'h0000);
        after_edge_collide("acc_cleared", 16'h0000);
        for (int k = 0; k < 2000; k++) begin
            logic [N-1:0] h;
            h = N'($urandom) & N'($urandom);
            if ($urandom_range(0, 1)) h[WL] = 1'b1;
            step((k % 40) < 3, $urandom_range(0, 9) < 8, h, $urandom_range(0, 9) == 0,
                 $urandom_range(0, N-1), $urandom_range(0, 9) < 8, $urandom_range(0, N-1));
        end
        repeat (3) step(0, 1, 16'h0021, 1, 4, 0, 9);
        step(0, 1, 16'h0005);
        #2 rst_n = 1'b0;
        #1 check_reset_outs("mid_rst");
        model_reset();
        bus.i_v_sync = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, 1, 16'h0003);
        repeat (5) step(1, 1, 16'h0021);
        repeat (5) step(0, 1, 16'h0011);
        step(1, 1, 16'h0000);
        repeat (3) step(0, 1, 16'h0000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
